// File: rtl/clock_counter_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clock_counter_bank_if                                            |
// | Brief   : Control/readout bundle for the multi-channel cycle counter bank  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface clock_counter_bank_if #(
  parameter int COUNTER_LENGTH = 64,
  parameter int NUM_CH         = 4
);
  logic [NUM_CH-1:0]                START;
  logic [NUM_CH-1:0]                STOP;
  logic [NUM_CH-1:0]                CLEAR;
  logic                             CAPTURE;
  logic [COUNTER_LENGTH-1:0]        THRESHOLD;
  logic [NUM_CH*COUNTER_LENGTH-1:0] COUNT;
  logic [NUM_CH*COUNTER_LENGTH-1:0] SNAP;
  logic                             SNAP_VALID;
  logic [NUM_CH-1:0]                RUNNING;
  logic [NUM_CH-1:0]                OVERFLOW;
  logic [NUM_CH-1:0]                MATCH;

  modport master (
    output START, STOP, CLEAR, CAPTURE, THRESHOLD,
    input  COUNT, SNAP, SNAP_VALID, RUNNING, OVERFLOW, MATCH
  );

  modport slave (
    input  START, STOP, CLEAR, CAPTURE, THRESHOLD,
    output COUNT, SNAP, SNAP_VALID, RUNNING, OVERFLOW, MATCH
  );
endinterface
`default_nettype wire

// File: rtl/clock_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : clock_counter_bank                                               |
// | Brief   : NUM_CH independent cycle counters with coherent global snapshot  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module clock_counter_bank #(
  parameter int COUNTER_LENGTH = 64,
  parameter int NUM_CH         = 4,
  parameter int SATURATE       = 0
) (
  input  wire logic            CLOCK,
  input  wire logic            RESET,
  clock_counter_bank_if.slave  bus
);

  localparam logic [COUNTER_LENGTH-1:0] C_ALL_ONES = '1;
  localparam logic [COUNTER_LENGTH-1:0] C_ONE      = {{(COUNTER_LENGTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [NUM_CH*COUNTER_LENGTH-1:0] w_count;
  logic [NUM_CH-1:0]                w_running;
  logic [NUM_CH-1:0]                w_overflow;
  logic [NUM_CH-1:0]                w_match;
  logic [NUM_CH*COUNTER_LENGTH-1:0] r_snap;
  logic                             r_snap_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                    r_state;
    logic [COUNTER_LENGTH-1:0] r_count;
    logic                      r_ovf;
    logic                      r_match;
    logic                      w_inc;
    logic                      w_at_max;
    logic [COUNTER_LENGTH-1:0] w_next;

    // An increment needs the channel already running and no stop/clear this edge
    assign w_inc    = (r_state == ST_RUN) && !bus.STOP[i] && !bus.CLEAR[i];
    assign w_at_max = (r_count == C_ALL_ONES);
    assign w_next   = r_count + C_ONE;

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_ovf   <= 1'b0;
        r_match <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (bus.START[i] && !bus.STOP[i]) r_state <= ST_RUN;
          ST_RUN:  if (bus.STOP[i])                  r_state <= ST_IDLE;
          default:                                   r_state <= ST_IDLE;
        endcase

        r_match <= 1'b0;
        if (bus.CLEAR[i]) begin
          r_count <= '0;
          r_ovf   <= 1'b0;
        end else if (w_inc) begin
          if (w_at_max) begin
            r_ovf <= 1'b1;
            // Saturating channels hold all-ones, so no new value and no match
            if (SATURATE == 0) begin
              r_count <= '0;
              r_match <= (bus.THRESHOLD == '0);
            end
          end else begin
            r_count <= w_next;
            r_match <= (w_next == bus.THRESHOLD);
          end
        end
      end
    end

    assign w_count[i*COUNTER_LENGTH +: COUNTER_LENGTH] = r_count;
    assign w_running[i]  = (r_state == ST_RUN);
    assign w_overflow[i] = r_ovf;
    assign w_match[i]    = r_match;
  end

  // Snapshot takes the pre-edge counts of every channel, so a same-edge clear is not seen
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_snap       <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= bus.CAPTURE;
      if (bus.CAPTURE) r_snap <= w_count;
    end
  end

  assign bus.COUNT      = w_count;
  assign bus.SNAP       = r_snap;
  assign bus.SNAP_VALID = r_snap_valid;
  assign bus.RUNNING    = w_running;
  assign bus.OVERFLOW   = w_overflow;
  assign bus.MATCH      = w_match;

endmodule
`default_nettype wire
